// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion; optional WB bypass via ID_EX_WB_BYPASS_EN
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd_addr,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_wr_en,
  input  logic [4:0]        wb_rd_addr,
  input  logic [XLEN-1:0]   wb_wr_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [PERF_W-1:0] perf_bubbles
);

  logic            lu_hazard;
  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic [XLEN-1:0] hold_rs1;
  logic [XLEN-1:0] hold_rs2;

  // A load in EX whose result a real ID instruction needs cannot be forwarded in time
  always_comb begin
    lu_hazard = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
                ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    id_stall  = (lu_hazard || ex_stall) && !flush;
  end

`ifdef ID_EX_WB_BYPASS_EN
  // Register file is read-before-write, so same-cycle WB writes are merged here; x0 is hard zero
  always_comb begin
    rs1_op   = rf_rs1_data;
    rs2_op   = rf_rs2_data;
    hold_rs1 = ex_rs1_data;
    hold_rs2 = ex_rs2_data;
    if (id_rs1_addr == 5'd0)
      rs1_op = '0;
    else if (wb_wr_en && (wb_rd_addr == id_rs1_addr))
      rs1_op = wb_wr_data;
    if (id_rs2_addr == 5'd0)
      rs2_op = '0;
    else if (wb_wr_en && (wb_rd_addr == id_rs2_addr))
      rs2_op = wb_wr_data;
    if (wb_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs1_addr))
      hold_rs1 = wb_wr_data;
    if (wb_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs2_addr))
      hold_rs2 = wb_wr_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr_en, wb_rd_addr, wb_wr_data};

  // Operands pass straight through; the EX forwarding unit is responsible for WB results
  always_comb begin
    rs1_op   = rf_rs1_data;
    rs2_op   = rf_rs2_data;
    hold_rs1 = ex_rs1_data;
    hold_rs2 = ex_rs2_data;
  end
`endif

  // One action per edge: flush, then hold, then bubble, then capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (flush || (!ex_stall && lu_hazard)) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (ex_stall) begin
      ex_rs1_data  <= hold_rs1;
      ex_rs2_data  <= hold_rs2;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_rs1_data  <= rs1_op;
      ex_rs2_data  <= rs2_op;
      ex_imm       <= id_imm;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_reg_write <= id_reg_write && id_valid;
      ex_ctrl      <= id_ctrl;
    end
  end

  // Saturating count of bubbles actually inserted for load-use hazards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      perf_bubbles <= '0;
    else if (!flush && !ex_stall && lu_hazard && (perf_bubbles != '1))
      perf_bubbles <= perf_bubbles + 1'b1;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register between decode and execute in the RV32I 5-stage core. It captures the register-file read data and decoded fields each cycle, and detects load-use hazards to insert bubbles. It applies the WB-to-ID write bypass that the register file does not provide. It also honours downstream stall and branch flush, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width
CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through
PERF_W, 16, width of saturating bubble counter

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  PC of decoded instruction
id_rs1_addr  in  5  source 1 index (also drives register file read port)
id_rs2_addr  in  5  source 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd_addr  in  5  destination index
id_imm  in  XLEN  sign-extended immediate
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes rd
id_ctrl  in  CTRL_W  remaining control bundle
rf_rs1_data  in  XLEN  register file read data 1
rf_rs2_data  in  XLEN  register file read data 2
wb_wr_en  in  1  WB stage write enable (same signal driving register file)
wb_rd_addr  in  5  WB destination index
wb_wr_data  in  XLEN  WB write data
ex_stall  in  1  downstream hold request
flush  in  1  squash decode/EX slot (taken branch/jump)
id_stall  out  1  hold PC and IF/ID register
ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data, ex_imm, ex_mem_read, ex_reg_write, ex_ctrl  out  (widths as id_ counterparts)  registered EX-stage fields
perf_bubbles  out  PERF_W  count of load-use bubbles inserted

Behaviour:
- Clock: clk. Reset: reset_n, asynchronous, active-low. The clock and reset port names and the reset polarity/synchronicity are fixed.
- Reset: every registered output, including perf_bubbles, is 0. id_stall is therefore 0 out of reset.
- lu_hazard (combinational) is asserted when all of the following hold:
  - id_valid, ex_valid and ex_mem_read are 1;
  - ex_rd_addr != 0;
  - (id_rs1_used and id_rs1_addr == ex_rd_addr) or (id_rs2_used and id_rs2_addr == ex_rd_addr).
- id_stall = (lu_hazard | ex_stall) & ~flush. It is combinational.
- Bypassed operand (per source): wb_wr_data if wb_wr_en and wb_rd_addr != 0 and wb_rd_addr == source addr; otherwise rf data. Index 0 always yields 0.
- Each rising edge applies exactly one action, in this priority order:
  1. flush: ex_valid, ex_reg_write, ex_mem_read and ex_ctrl are set to 0. Other fields hold. Counter unchanged.
  2. ex_stall: all fields hold. A held ex_rsN_data is refreshed with wb_wr_data when the bypass condition matches ex_rsN_addr, so the held operand never goes stale.
  3. lu_hazard: insert a bubble (ex_valid, ex_reg_write, ex_mem_read, ex_ctrl set to 0). perf_bubbles increments, saturating at all-ones.
  4. Otherwise capture: ex_valid <= id_valid. ex_reg_write and ex_mem_read are gated by id_valid. All other fields load from id_ inputs and the bypassed operands.
- Latency: 1 cycle from ID inputs to ex_ outputs. A load-use stall costs exactly 1 bubble.
- Simultaneous flush and lu_hazard: flush wins, and no count is taken.
- An invalid ID slot (id_valid=0) never raises a hazard.
- Reset asserted mid-operation clears state immediately.

Optional Feature:
Macro ID_EX_WB_BYPASS_EN.
- Defined: WB-to-ID bypass applies as described, both on capture and on held-operand refresh.
- Undefined: operands come straight from rf_rsN_data, with no held refresh. Correct results then depend on the downstream forwarding unit covering WB.

Test Plan:
- Reset, then id_valid=1, pc=0x100, rs1=3 (rf=0x11), rd=5 -> next cycle ex_valid=1, ex_pc=0x100, ex_rs1_data=0x11, ex_rd_addr=5.
- EX holds a load to x7; ID is add using rs2=7 -> id_stall=1 for 1 cycle, then a bubble (ex_valid=0, ex_reg_write=0), perf_bubbles=1. Next cycle the add is captured.
- wb_wr_en=1, wb_rd_addr=4, data 0xDEAD; ID reads rs1=4, rf shows old 0x0 -> ex_rs1_data=0xDEAD with bypass enabled, 0x0 with bypass disabled. Same write to x0 -> ex data 0.
- flush=1 together with a load-use hazard -> ex_valid=0, id_stall=0, perf_bubbles unchanged.
- ex_stall=1 for 3 cycles while WB writes rs1 of the held instruction with 0x55 -> all fields hold except ex_rs1_data=0x55. The instruction releases when ex_stall drops.
- Force 2^PERF_W+2 load-use hazards -> perf_bubbles saturates at 0xFFFF. Assert reset_n low mid-stall -> all outputs 0 asynchronously.
